// File: rtl/count_game_pkg.sv
// Shared types and default timing constants for the count_game countdown controller.
package count_game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int TICK_DIV_DEF  = 1000;
  localparam int START_VAL_DEF = 7;
  localparam int BLINK_DIV_DEF = 250;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for a raw button followed by a registered rising-edge pulse.
module btn_edge_sync
  import count_game_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  logic s1_q, s2_q, s3_q;
  logic pulse_d, pulse_q;

  always_comb pulse_d = s2_q & ~s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/dz_count_ctrl.sv
// Countdown sequencer feeding the dot-matrix driver: digit code num, blank/blink enable st.
module dz_count_ctrl
  import count_game_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int START_VAL = START_VAL_DEF,
  parameter int BLINK_DIV = BLINK_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  output logic [2:0] num,
  output logic       st,
  output logic       done,
  output logic       running
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam int BW = cnt_w(BLINK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [2:0]    START_NUM = 3'(START_VAL);

  logic start_p, pause_p;

  btn_edge_sync u_start_sync (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (start_btn),
    .pulse   (start_p)
  );

  btn_edge_sync u_pause_sync (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (pause_btn),
    .pulse   (pause_p)
  );

  state_e          state_q, state_d;
  logic [2:0]      num_q, num_d;
  logic            st_q, st_d;
  logic            done_q, done_d;
  logic            running_q, running_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            tick;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    st_d      = st_q;
    done_d    = done_q;
    running_d = running_q;
    presc_d   = presc_q;
    blink_d   = blink_q;
    tick      = (state_q == RUN) && (presc_q == PRESC_MAX);

    // start wins over pause and over a coincident tick in every state
    if (start_p) begin
      state_d   = RUN;
      num_d     = START_NUM;
      st_d      = 1'b1;
      done_d    = 1'b0;
      running_d = 1'b1;
      presc_d   = '0;
      blink_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick && (num_q == 3'd1)) begin
            state_d   = DONE;
            num_d     = 3'd0;
            done_d    = 1'b1;
            running_d = 1'b0;
            st_d      = 1'b1;
            blink_d   = '0;
          end else begin
            if (tick) num_d = num_q - 3'd1;
            if (pause_p) begin
              state_d   = PAUSE;
              running_d = 1'b0;
            end
          end
        end
        PAUSE: begin
          if (pause_p) begin
            state_d   = RUN;
            running_d = 1'b1;
          end
        end
        DONE: begin
          if (blink_q == BLINK_MAX) begin
            blink_d = '0;
            st_d    = ~st_q;
          end else begin
            blink_d = blink_q + BW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= 3'd0;
      st_q      <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      presc_q   <= '0;
      blink_q   <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      st_q      <= st_d;
      done_q    <= done_d;
      running_q <= running_d;
      presc_q   <= presc_d;
      blink_q   <= blink_d;
    end
  end

  assign num     = num_q;
  assign st      = st_q;
  assign done    = done_q;
  assign running = running_q;

endmodule

// File: tb/tb_dz_count_ctrl.sv
// Directed bench for dz_count_ctrl with TICK_DIV=4, BLINK_DIV=3, START_VAL=7.
module tb_dz_count_ctrl;
  import count_game_pkg::*;

  localparam int TD = 4;
  localparam int BD = 3;
  localparam int SV = START_VAL_DEF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic [2:0] num;
  logic       st, done, running;

  int n_asserts = 0;
  int n_fail = 0;

  dz_count_ctrl #(
    .TICK_DIV  (TD),
    .START_VAL (SV),
    .BLINK_DIV (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .pause_btn (pause_btn),
    .num       (num),
    .st        (st),
    .done      (done),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e_num, input int e_st,
                         input int e_done, input int e_run);
    chk({tag, ".num"}, int'(num), e_num);
    chk({tag, ".st"}, int'(st), e_st);
    chk({tag, ".done"}, int'(done), e_done);
    chk({tag, ".running"}, int'(running), e_run);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    cyc(1);
    chk_out("reset", 0, 0, 0, 0);
    rst = 1'b0;
    cyc(2);

    // start press: visible three edges after the raw rise is sampled
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    cyc(2);
    chk_out("start_latency", 0, 0, 0, 0);
    cyc(1);
    chk_out("start", 7, 1, 0, 1);
    cyc(4);
    chk("step6", int'(num), 6);

    // pause lands with num=5 and prescaler frozen at 2
    cyc(2);
    pause_btn = 1'b1;
    cyc(1);
    pause_btn = 1'b0;
    cyc(3);
    chk_out("pause_entry", 5, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("pause_hold.num", int'(num), 5);
      chk("pause_hold.running", int'(running), 0);
    end

    // resume: next decrement two clocks after the FSM re-enters RUN
    pause_btn = 1'b1;
    cyc(1);
    pause_btn = 1'b0;
    cyc(3);
    chk_out("resume", 5, 1, 0, 1);
    cyc(1);
    chk("resume+1", int'(num), 5);
    cyc(1);
    chk("resume+2", int'(num), 4);

    // start and pause together at num=3: reload wins, no PAUSE
    cyc(2);
    start_btn = 1'b1;
    pause_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    pause_btn = 1'b0;
    cyc(1);
    chk("pre_both.num", int'(num), 3);
    cyc(1);
    chk("pre_both2.num", int'(num), 3);
    cyc(1);
    chk_out("both", 7, 1, 0, 1);
    cyc(3);
    chk_out("both+3", 7, 1, 0, 1);
    cyc(1);
    chk("both+4", int'(num), 6);

    // full countdown into DONE
    cyc(23);
    chk_out("last1", 1, 1, 0, 1);
    cyc(1);
    chk_out("done_entry", 0, 1, 1, 0);
    for (int j = 1; j <= 6; j++) begin
      cyc(1);
      chk("blink.st", int'(st), ((j / BD) % 2 == 0) ? 1 : 0);
      chk("blink.num", int'(num), 0);
      chk("blink.done", int'(done), 1);
    end

    // pause ignored in DONE
    pause_btn = 1'b1;
    cyc(1);
    pause_btn = 1'b0;
    cyc(4);
    chk("done_pause.done", int'(done), 1);
    chk("done_pause.running", int'(running), 0);

    // restart from DONE, then pause with num=4
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    cyc(3);
    chk_out("restart", 7, 1, 0, 1);
    cyc(10);
    pause_btn = 1'b1;
    cyc(1);
    pause_btn = 1'b0;
    cyc(3);
    chk_out("pause4", 4, 1, 0, 0);

    // asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    cyc(1);
    rst = 1'b0;
    pause_btn = 1'b1;
    cyc(1);
    pause_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk_out("idle_pause", 0, 0, 0, 0);
    end

    // held start: one reload, normal countdown, then DONE blinking
    start_btn = 1'b1;
    for (int j = 1; j <= 50; j++) begin
      int e_num, e_st, e_done, e_run;
      cyc(1);
      if (j < 4) begin
        e_num = 0; e_st = 0; e_done = 0; e_run = 0;
      end else if (j < 32) begin
        e_num = SV - (j - 4) / TD; e_st = 1; e_done = 0; e_run = 1;
      end else begin
        e_num = 0; e_done = 1; e_run = 0;
        e_st = (((j - 32) / BD) % 2 == 0) ? 1 : 0;
      end
      chk_out("held", e_num, e_st, e_done, e_run);
    end
    start_btn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/dz_count_ctrl.md
Name: dz_count_ctrl

Overview:
- Countdown sequencer that drives the 8x8 dot-matrix display driver in count_game.
- Produces the digit code num[2:0] and display enable st for the display driver.
- Counts down from START_VAL to 0, one step per TICK_DIV clocks, with start/restart and pause/resume from push buttons.
- At zero it blinks the display through st until the next start press.

Parameters:
- TICK_DIV, 1000: clk cycles per count step; 1 s at the 1 kHz scan clock; legal range >=2.
- START_VAL, 7: value loaded on start; 3 bits wide, legal range 1..7.
- BLINK_DIV, 250: clk cycles per half-period of the DONE blink; legal range >=2.

Ports:
- clk  input  1  system clock, the same 1 kHz clock used by the display driver
- rst  input  1  asynchronous, active-high reset
- start_btn  input  1  raw start/restart button, active-high, asynchronous to clk
- pause_btn  input  1  raw pause/resume button, active-high, asynchronous to clk
- num  output  3  digit code to the display driver
- st  output  1  display enable; 0 blanks the matrix
- done  output  1  high while in DONE
- running  output  1  high while in RUN

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - state=IDLE, num=0, st=0, done=0, running=0
  - prescaler=0, blink counter=0, all synchronizer flops=0
- Reset asserted mid-count aborts immediately to these values.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then a registered rising-edge detect: s2 & ~s3.
  - The resulting one-cycle pulses are start_p and pause_p.
  - A raw rising edge sampled at clk edge k produces the state/output update at edge k+3.
  - A held button produces exactly one pulse.
  - No debounce is done in this block; the upstream board already debounces.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - tick is asserted when prescaler==TICK_DIV-1; the prescaler then wraps to 0.
  - Cleared on every entry to RUN from IDLE or DONE, and on any start_p.
  - Frozen (not cleared) in PAUSE.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE: st=0, num=0. On start_p -> RUN, num=START_VAL, st=1. pause_p is ignored.
  - RUN: st=1, running=1.
    - On tick: if num==1, then num=0 and go to DONE; otherwise num=num-1.
    - On pause_p -> PAUSE.
    - On start_p: reload num=START_VAL, clear prescaler, stay in RUN.
  - PAUSE: st=1, num held, prescaler held.
    - On pause_p -> RUN, with the prescaler resuming from its held value.
    - On start_p -> RUN with reload.
  - DONE: num=0, done=1. st toggles every BLINK_DIV cycles, starting with st=1 on entry.
    - On start_p -> RUN with reload, st=1, blink counter cleared.
    - pause_p is ignored.
- Simultaneous events:
  - start_p and pause_p in the same cycle: start_p wins in every state.
  - start_p in the same cycle as tick in RUN: the reload wins and the tick is discarded.
  - pause_p in the same cycle as tick: the decrement is applied and the FSM enters PAUSE.
- Arithmetic: num is 3-bit unsigned. A decrement never occurs at num==0, so no wrap-around is possible.
- All outputs are registered. No combinational path exists from inputs to outputs.

Decomposition:
- Shared package count_game_pkg:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - Default TICK_DIV, START_VAL and BLINK_DIV constants, shared with the top level and the testbench.
- One sub-module, btn_edge_sync: a 2-flop synchronizer plus rising-edge pulse, instantiated twice.

Test Plan (all scenarios use TICK_DIV=4, BLINK_DIV=3, START_VAL=7):
- Reset release, then start_btn pulse -> num=7, st=1, running=1 three edges after the raw rise. num then steps 6,5,...,1 every 4 clocks.
- Full countdown -> the tick at num==1 gives num=0, done=1, running=0. st then toggles 1,1,1,0,0,0,1... while num stays 0.
- pause_btn at prescaler=2 with num=5 -> num stays 5 for 20 clocks. After a second pause pulse, the next decrement to 4 occurs 2 clocks later.
- start_btn and pause_btn rising in the same cycle during RUN with num=3 -> num=7, state RUN, prescaler=0, no PAUSE entry.
- rst asserted asynchronously between clock edges while in PAUSE with num=4 -> num=0, st=0, done=0 immediately. After release, the FSM stays in IDLE and ignores pause_btn.
- start_btn held high for 50 clocks from IDLE -> exactly one reload. A countdown from 7 proceeds normally with no further reloads.
